// File: rtl/data_ram_pipe.sv
// Parametrised data RAM: one write port, one pipelined read port, sequential clear sweep.
// Define DATA_RAM_PARITY_EN to store a parity bit per word and report parityErr on reads.
module data_ram_pipe #(
  parameter int WIDTH       = 16,
  parameter int LENGTH      = 8,
  parameter int READ_LAT    = 2,
  parameter int WRITE_FIRST = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              clrReq,
  input  logic              writeEnable,
  input  logic [LENGTH-1:0] addr,
  input  logic [WIDTH-1:0]  writeData,
  input  logic              readEnable,
  input  logic [LENGTH-1:0] readAddr,
  input  logic              parityInject,
  output logic              busy,
  output logic              dataReady,
  output logic [WIDTH-1:0]  readData,
  output logic              parityErr,
  output logic              dbg_state
);

`ifdef DATA_RAM_PARITY_EN
  localparam int MW = WIDTH + 1;
`else
  localparam int MW = WIDTH;
`endif

  typedef enum logic {ST_SWEEP = 1'b0, ST_IDLE = 1'b1} state_t;

  state_t                          r_state;
  state_t                          w_next;
  logic [LENGTH-1:0]               r_cnt;
  logic [MW-1:0]                   r_mem [2**LENGTH];
  logic [READ_LAT-1:0]             r_pv;
  logic [READ_LAT-1:0][MW-1:0]     r_pd;
  logic                            w_wr_acc;
  logic                            w_rd_acc;
  logic [MW-1:0]                   w_wr_word;
  logic [MW-1:0]                   w_rd_word;

  // Requests are only honoured in IDLE and dropped on the edge that starts a sweep.
  assign w_wr_acc = (r_state == ST_IDLE) && !clrReq && writeEnable;
  assign w_rd_acc = (r_state == ST_IDLE) && !clrReq && readEnable;

`ifdef DATA_RAM_PARITY_EN
  assign w_wr_word = {(^writeData) ^ parityInject, writeData};
`else
  assign w_wr_word = writeData;
`endif

  assign w_rd_word = ((WRITE_FIRST != 0) && w_wr_acc && (addr == readAddr)) ?
                     w_wr_word : r_mem[readAddr];

  always_ff @(negedge clk or negedge clr) begin
    if (!clr) r_state <= ST_SWEEP;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_SWEEP: if (r_cnt == {LENGTH{1'b1}}) w_next = ST_IDLE;
      ST_IDLE:  if (clrReq) w_next = ST_SWEEP;
      default:  w_next = ST_SWEEP;
    endcase
  end

  always_comb begin
    busy      = (r_state == ST_SWEEP);
    dbg_state = r_state;
  end

  always_ff @(negedge clk or negedge clr) begin
    if (!clr)                      r_cnt <= '0;
    else if (r_state == ST_SWEEP)  r_cnt <= r_cnt + 1'b1;
    else if (clrReq)               r_cnt <= '0;
  end

  // Array has no reset; the sweep zeroes it (all-zero word carries correct parity 0).
  always_ff @(negedge clk) begin
    if (r_state == ST_SWEEP) r_mem[r_cnt] <= '0;
    else if (w_wr_acc)       r_mem[addr]  <= w_wr_word;
  end

  always_ff @(negedge clk or negedge clr) begin
    if (!clr) begin
      r_pv <= '0;
      r_pd <= '0;
    end else begin
      r_pv[0] <= w_rd_acc;
      if (w_rd_acc) r_pd[0] <= w_rd_word;
      for (int i = 1; i < READ_LAT; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pd[i] <= r_pd[i-1];
      end
    end
  end

  always_ff @(negedge clk or negedge clr) begin
    if (!clr) begin
      dataReady <= 1'b0;
      readData  <= '0;
    end else begin
      dataReady <= r_pv[READ_LAT-1];
      if (r_pv[READ_LAT-1]) readData <= r_pd[READ_LAT-1][WIDTH-1:0];
    end
  end

`ifdef DATA_RAM_PARITY_EN
  logic r_perr;
  always_ff @(negedge clk or negedge clr) begin
    if (!clr) r_perr <= 1'b0;
    else if (r_pv[READ_LAT-1])
      r_perr <= r_pd[READ_LAT-1][WIDTH] ^ (^r_pd[READ_LAT-1][WIDTH-1:0]);
  end
  assign parityErr = r_perr;
`else
  logic w_unused_inject;
  assign w_unused_inject = parityInject;
  assign parityErr       = 1'b0;
`endif

endmodule

// File: tb/tb_data_ram_pipe.sv
// Bench for data_ram_pipe: directed vectors, expected-queue scoreboard, two WRITE_FIRST variants.
module tb_data_ram_pipe;
  localparam int W  = 16;
  localparam int L  = 8;
  localparam int RL = 2;

  logic         clk = 1'b0;
  logic         clr;
  logic         clrReq, writeEnable, readEnable, parityInject;
  logic [L-1:0] addr, readAddr;
  logic [W-1:0] writeData;
  logic         busy, dataReady, parityErr, dbg_state;
  logic [W-1:0] readData;
  logic         busy0, dataReady0, parityErr0, dbg_state0;
  logic [W-1:0] readData0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n;

  logic [W:0] exp_q[$];
  logic [W:0] exp0_q[$];
  int         exp_t_q[$];
  logic [W:0] mon_e;
  logic [W:0] mon_e0;
  int         mon_t;

  data_ram_pipe #(.WIDTH(W), .LENGTH(L), .READ_LAT(RL), .WRITE_FIRST(1)) u_dut (
    .clk(clk), .clr(clr), .clrReq(clrReq), .writeEnable(writeEnable), .addr(addr),
    .writeData(writeData), .readEnable(readEnable), .readAddr(readAddr),
    .parityInject(parityInject), .busy(busy), .dataReady(dataReady),
    .readData(readData), .parityErr(parityErr), .dbg_state(dbg_state)
  );

  data_ram_pipe #(.WIDTH(W), .LENGTH(L), .READ_LAT(RL), .WRITE_FIRST(0)) u_dut_wf0 (
    .clk(clk), .clr(clr), .clrReq(clrReq), .writeEnable(writeEnable), .addr(addr),
    .writeData(writeData), .readEnable(readEnable), .readAddr(readAddr),
    .parityInject(parityInject), .busy(busy0), .dataReady(dataReady0),
    .readData(readData0), .parityErr(parityErr0), .dbg_state(dbg_state0)
  );

  // Clock / edge counter: the design updates on falling edges, the bench drives and samples on rising.
  always #5 clk = ~clk;
  always @(negedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic we, input logic [L-1:0] wa, input logic [W-1:0] wd,
                       input logic re, input logic [L-1:0] ra, input logic inj, input logic cq);
    @(posedge clk);
    writeEnable  = we;
    addr         = wa;
    writeData    = wd;
    readEnable   = re;
    readAddr     = ra;
    parityInject = inj;
    clrReq       = cq;
  endtask

  task automatic drive_idle();
    drive(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic idle_n(input int k);
    for (int i = 0; i < k; i++) drive_idle();
  endtask

  // Call right after the drive that presents the read; accept happens on the next falling edge.
  task automatic push_rd(input logic [W-1:0] d1, input logic [W-1:0] d0, input logic pe);
    exp_q.push_back({pe, d1});
    exp0_q.push_back({pe, d0});
    exp_t_q.push_back(cyc + 1 + RL);
  endtask

  task automatic count_busy(output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 400) begin
      drive_idle();
      cnt++;
    end
  endtask

  task automatic pulse_clr(input string tag);
    clr = 1'b0;
    #1;
    check({tag, "_busy"},  busy, 1);
    check({tag, "_ready"}, dataReady, 0);
    check({tag, "_rdata"}, readData, 0);
    #1;
    clr = 1'b1;
  endtask

  // Monitor: pops one expectation per dataReady pulse on each instance.
  always @(posedge clk) begin
    if (dataReady === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_ready", 1, 0);
      else begin
        mon_e = exp_q.pop_front();
        mon_t = exp_t_q.pop_front();
        check("rd_data", readData, mon_e[W-1:0]);
        check("rd_perr", parityErr, mon_e[W]);
        check("rd_latency", cyc, mon_t);
      end
    end
    if (dataReady0 === 1'b1) begin
      if (exp0_q.size() == 0) check("unexpected_ready_wf0", 1, 0);
      else begin
        mon_e0 = exp0_q.pop_front();
        check("rd_data_wf0", readData0, mon_e0[W-1:0]);
        check("rd_perr_wf0", parityErr0, mon_e0[W]);
      end
    end
  end

  initial begin
    clr = 1'b0;
    writeEnable = 0; addr = '0; writeData = '0; readEnable = 0; readAddr = '0;
    parityInject = 0; clrReq = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1);
    check("rst_ready", dataReady, 0);
    check("rst_rdata", readData, 0);
    check("rst_perr", parityErr, 0);
    check("rst_state", dbg_state, 0);

    // Power-on sweep length
    @(posedge clk);
    clr = 1'b1;
    count_busy(n);
    check("busy_len_por", n, 256);
    check("idle_state", dbg_state, 1);

    // Swept words read back as zero, back to back
    drive(0, 0, 0, 1, 8'd0, 0, 0);   push_rd(16'h0000, 16'h0000, 0);
    drive(0, 0, 0, 1, 8'd128, 0, 0); push_rd(16'h0000, 16'h0000, 0);
    drive(0, 0, 0, 1, 8'd255, 0, 0); push_rd(16'h0000, 16'h0000, 0);
    idle_n(3);

    // Single write then read
    drive(1, 8'd7, 16'hA5C3, 0, 0, 0, 0);
    drive_idle();
    drive(0, 0, 0, 1, 8'd7, 0, 0); push_rd(16'hA5C3, 16'hA5C3, 0);
    idle_n(3);

    // Pipelined reads in order
    drive(1, 8'd1, 16'h0011, 0, 0, 0, 0);
    drive(1, 8'd2, 16'h0022, 0, 0, 0, 0);
    drive(1, 8'd3, 16'h0033, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 8'd1, 0, 0); push_rd(16'h0011, 16'h0011, 0);
    drive(0, 0, 0, 1, 8'd2, 0, 0); push_rd(16'h0022, 16'h0022, 0);
    drive(0, 0, 0, 1, 8'd3, 0, 0); push_rd(16'h0033, 16'h0033, 0);
    idle_n(3);

    // Same-edge write/read collision
    drive(1, 8'd9, 16'hFFFF, 0, 0, 0, 0);
    drive(1, 8'd9, 16'h1234, 1, 8'd9, 0, 0); push_rd(16'h1234, 16'hFFFF, 0);
    drive_idle();
    drive(0, 0, 0, 1, 8'd9, 0, 0); push_rd(16'h1234, 16'h1234, 0);
    idle_n(3);

    // Write after an accepted read does not alter it
    drive(0, 0, 0, 1, 8'd7, 0, 0); push_rd(16'hA5C3, 16'hA5C3, 0);
    drive(1, 8'd7, 16'hBEEF, 0, 0, 0, 0);
    drive_idle();
    drive(0, 0, 0, 1, 8'd7, 0, 0); push_rd(16'hBEEF, 16'hBEEF, 0);
    idle_n(4);
    #1;
    check("rdata_hold", readData, 16'hBEEF);
    check("ready_low_idle", dataReady, 0);

    // In-flight read survives sweep start; clrReq mid-sweep ignored; requests while busy ignored
    drive(0, 0, 0, 1, 8'd1, 0, 0); push_rd(16'h0011, 16'h0011, 0);
    drive(1, 8'd2, 16'hDEAD, 1, 8'd2, 0, 1);
    drive_idle();
    n = 0;
    while (busy === 1'b1 && n < 400) begin
      if (n == 100)      drive(0, 0, 0, 0, 0, 0, 1);
      else if (n == 250) drive(1, 8'd5, 16'h5555, 1, 8'd6, 0, 0);
      else               drive_idle();
      n++;
    end
    check("busy_len_clrreq", n, 256);
    drive(0, 0, 0, 1, 8'd5, 0, 0); push_rd(16'h0000, 16'h0000, 0);
    drive(0, 0, 0, 1, 8'd2, 0, 0); push_rd(16'h0000, 16'h0000, 0);
    drive(0, 0, 0, 1, 8'd1, 0, 0); push_rd(16'h0000, 16'h0000, 0);
    idle_n(3);

    // Reset flushes an in-flight read
    drive(1, 8'd4, 16'h0077, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 8'd4, 0, 0); push_rd(16'h0077, 16'h0077, 0);
    idle_n(3);
    drive(0, 0, 0, 1, 8'd4, 0, 0);
    drive_idle();
    pulse_clr("flush");
    count_busy(n);
    check("busy_len_flush", n, 256);

    // Reset in the middle of a sweep restarts it
    drive(0, 0, 0, 0, 0, 0, 1);
    drive_idle();
    idle_n(50);
    pulse_clr("midsweep");
    count_busy(n);
    check("busy_len_midsweep", n, 256);
    drive(0, 0, 0, 1, 8'd4, 0, 0);   push_rd(16'h0000, 16'h0000, 0);
    drive(0, 0, 0, 1, 8'd200, 0, 0); push_rd(16'h0000, 16'h0000, 0);
    idle_n(3);

`ifdef DATA_RAM_PARITY_EN
    drive(1, 8'd3, 16'h0001, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 8'd3, 0, 0); push_rd(16'h0001, 16'h0001, 1);
    idle_n(3);
    drive(1, 8'd3, 16'h0001, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 8'd3, 0, 0); push_rd(16'h0001, 16'h0001, 0);
    idle_n(3);
`endif

    idle_n(5);
    check("queue_drained", exp_q.size(), 0);
    check("queue_drained_wf0", exp0_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_ram_pipe.md
Name: data_ram_pipe

Overview:
- Parametrised successor to the processor's data RAM: single-clock, one write port plus one pipelined read port, configurable word width, depth and read latency.
- Replaces the single-edge whole-array clear with a sequential clear engine (one word per cycle) and a busy flag.
- Sits between the processor datapath and its load/store logic.
- Read completion is signalled by a one-cycle dataReady pulse.

Parameters:
- WIDTH, 16, data word width in bits.
- LENGTH, 8, address width; depth = 2**LENGTH words.
- READ_LAT, 2, edges from read accept to dataReady; legal range 1..4.
- WRITE_FIRST, 1, same-edge read/write to the same address: 1 returns new data, 0 returns old data.

Ports:
- clk  input  1  clock; all state updates on the falling edge.
- clr  input  1  asynchronous active-low reset.
- clrReq  input  1  synchronous active-high request to start a clear sweep.
- writeEnable  input  1  write strobe.
- addr  input  LENGTH  write address.
- writeData  input  WIDTH  write data.
- readEnable  input  1  read request.
- readAddr  input  LENGTH  read address.
- parityInject  input  1  with the macro: store corrupted parity; ignored without it.
- busy  output  1  clear sweep in progress; requests are ignored while high.
- dataReady  output  1  one-cycle pulse: readData is valid.
- readData  output  WIDTH  read result; holds its value between completions.
- parityErr  output  1  valid with dataReady; parity mismatch on the returned word.

Behaviour:
- Reset (clr=0, asynchronous): busy=1, dataReady=0, readData=0, parityErr=0, read pipeline flushed, sweep counter=0, state=SWEEP. Memory contents are not reset directly; the sweep zeroes them after clr releases.
- States: SWEEP and IDLE.
- SWEEP: each falling edge writes 0 to mem[cnt] and increments cnt. After the edge that writes address 2**LENGTH-1, go to IDLE and drop busy. Busy is high for exactly 2**LENGTH edges.
- IDLE + clrReq=1: go to SWEEP with cnt=0 and busy=1 on the same edge. Any read or write presented on that edge is dropped.
- clrReq while in SWEEP: ignored; the sweep does not restart.
- Reset mid-sweep: sweep restarts at address 0; in-flight reads are discarded with no dataReady.
- Write (IDLE, writeEnable=1): mem[addr] <= writeData on that edge.
- Read (IDLE, readEnable=1): the array is sampled at the accept edge. readData updates and dataReady pulses READ_LAT edges later.
- The read pipeline is fully pipelined: one accept per cycle, results returned in order, back-to-back dataReady pulses allowed.
- Same-edge write and read to the same address: WRITE_FIRST=1 returns writeData; WRITE_FIRST=0 returns the prior contents.
- A write after a read is accepted never changes that read's result.
- Reads already in flight when a sweep starts still complete with their captured data.
- Requests while busy=1: no array change, no dataReady.
- No completing read on an edge: dataReady=0, readData and parityErr hold their values.
- Addresses are LENGTH bits, so there is no out-of-range access.

Optional Feature:
- Macro: DATA_RAM_PARITY_EN.
- Defined:
  - Each word stores one extra bit, ^writeData, inverted when parityInject=1. The sweep stores parity 0, which is correct for a zero word.
  - parityErr = stored parity XOR ^(stored data), registered and delivered alongside dataReady.
- Undefined:
  - No extra storage.
  - parityErr is constant 0 and parityInject is unused.

Test Plan (WIDTH=16, LENGTH=8, READ_LAT=2):
- Release clr, idle inputs -> busy high for 256 falling edges then 0; reading addresses 0, 128 and 255 returns 16'h0000 with dataReady pulses.
- Write 16'hA5C3 to address 7, then read address 7 -> dataReady exactly 2 edges after accept, readData=16'hA5C3, pulse one cycle wide.
- Reads of addresses 1, 2, 3 on consecutive edges holding 16'h0011, 16'h0022, 16'h0033 -> three consecutive dataReady pulses, data in order.
- Same-edge write of 16'h1234 to address 9 (old value 16'hFFFF) and read of address 9 -> returns 16'h1234 with WRITE_FIRST=1, 16'hFFFF with WRITE_FIRST=0.
- Assert clrReq at sweep count 100, then pulse clr low at count 50 of a new sweep -> first clrReq ignored; sweep restarts at 0; busy high for 256 edges after clr release; no dataReady from a flushed read.
- With DATA_RAM_PARITY_EN: write 16'h0001 to address 3 with parityInject=1, then read -> parityErr=1; rewrite with parityInject=0 and read -> parityErr=0.
